// File: rtl/alu_rr_arbiter_pkg.sv
// Shared definitions for the round-robin ALU arbiter: ALU operation codes
// and the arbiter FSM state encoding.
package alu_rr_arbiter_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_SRL  = 3'd4,
        ALU_SRA  = 3'd5,
        ALU_SGTU = 3'd6,
        ALU_SGT  = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_rr_arbiter_alu.sv
// Purely combinational 32-bit ALU shared by both arbiter requesters.
// Shift amounts use the full 32-bit B operand, so large shifts saturate.
module alu_rr_arbiter_alu (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  ALUOp,
    output logic [31:0] C
);
    import alu_rr_arbiter_pkg::*;

    logic       shift_big;
    logic [4:0] shamt;

    // Any set bit above bit 4 means the shift reaches or passes the word width.
    always_comb begin
        shift_big = |B[31:5];
        shamt     = shift_big ? 5'd31 : B[4:0];
    end

    always_comb begin
        C = '0;
        case (ALUOp)
            ALU_ADD:  C = A + B;
            ALU_SUB:  C = A - B;
            ALU_AND:  C = A & B;
            ALU_OR:   C = A | B;
            ALU_SRL:  C = shift_big ? 32'd0 : (A >> shamt);
            ALU_SRA:  C = $signed(A) >>> shamt;
            ALU_SGTU: C = {31'd0, (A > B)};
            ALU_SGT:  C = {31'd0, ($signed(A) > $signed(B))};
            default:  C = '0;
        endcase
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters with a
// req/gnt/done/ack handshake; the winner's operands are latched before use.
module alu_rr_arbiter #(
    parameter logic FIRST_GRANT = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic [31:0] A0,
    input  logic [31:0] B0,
    input  logic [2:0]  ALUOp0,
    input  logic        ack0,
    input  logic        req1,
    input  logic [31:0] A1,
    input  logic [31:0] B1,
    input  logic [2:0]  ALUOp1,
    input  logic        ack1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] C,
    output logic        busy
);
    import alu_rr_arbiter_pkg::*;

    state_t      state;
    state_t      state_next;
    logic        owner;
    logic        last_served;
    logic        pick;
    logic        any_req;
    logic        owner_ack;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [2:0]  op_q;
    logic [31:0] alu_c;

    alu_rr_arbiter_alu u_alu (
        .A     (a_q),
        .B     (b_q),
        .ALUOp (op_q),
        .C     (alu_c)
    );

    // On a tie the requester that was not served last wins.
    always_comb begin
        any_req   = req0 | req1;
        pick      = (req0 && req1) ? ~last_served : req1;
        owner_ack = owner ? ack1 : ack0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (any_req) state_next = S_EXEC;
            S_EXEC:  state_next = S_RESP;
            S_RESP:  if (owner_ack) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != S_IDLE);
        gnt0  = (state == S_EXEC) && !owner;
        gnt1  = (state == S_EXEC) && owner;
        done0 = (state == S_RESP) && !owner;
        done1 = (state == S_RESP) && owner;
    end

    // Operands are captured at the arbitration edge so requesters may change
    // them as soon as the grant is seen; C only moves when EXEC completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner       <= 1'b0;
            last_served <= ~FIRST_GRANT;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            C           <= '0;
        end else begin
            if (state == S_IDLE && any_req) begin
                owner <= pick;
                a_q   <= pick ? A1 : A0;
                b_q   <= pick ? B1 : B0;
                op_q  <= pick ? ALUOp1 : ALUOp0;
            end
            if (state == S_EXEC) begin
                C           <= alu_c;
                last_served <= owner;
            end
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter: directed handshake scenarios plus
// randomized traffic checked against an arithmetic ALU/arbitration model.
module tb_alu_rr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, ack0, ack1;
    logic [31:0] A0, B0, A1, B1;
    logic [2:0]  ALUOp0, ALUOp1;
    logic        gnt0, gnt1, done0, done1, busy;
    logic [31:0] C;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit last_served;

    alu_rr_arbiter #(.FIRST_GRANT(1'b0)) dut (
        .clk    (clk),
        .reset  (reset),
        .req0   (req0),
        .A0     (A0),
        .B0     (B0),
        .ALUOp0 (ALUOp0),
        .ack0   (ack0),
        .req1   (req1),
        .A1     (A1),
        .B1     (B1),
        .ALUOp1 (ALUOp1),
        .ack1   (ack1),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .done0  (done0),
        .done1  (done1),
        .C      (C),
        .busy   (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Reference ALU built from modular arithmetic rather than bit operators.
    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        longint m;
        longint ua;
        longint ub;
        longint sa;
        longint sb;
        m  = 64'd4294967296;
        ua = longint'(a);
        ub = longint'(b);
        sa = a[31] ? ua - m : ua;
        sb = b[31] ? ub - m : ub;
        case (op)
            3'd0: return 32'((ua + ub) % m);
            3'd1: return 32'((ua - ub + m) % m);
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return (ub >= 32) ? 32'd0 : 32'(ua / (64'd1 << ub));
            3'd5: return a[31] ? ~ref_alu(~a, b, 3'd4) : ref_alu(a, b, 3'd4);
            3'd6: return (ua > ub) ? 32'd1 : 32'd0;
            default: return (sa > sb) ? 32'd1 : 32'd0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit r, input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] op);
        if (r) begin
            A1 = a; B1 = b; ALUOp1 = op; req1 = 1'b1;
        end else begin
            A0 = a; B0 = b; ALUOp0 = op; req0 = 1'b1;
        end
    endtask

    // One complete transaction starting from IDLE at a falling edge.
    task automatic serve(input int ack_wait, input bit drop_req, input bit scramble,
                         input bit poke_other, output bit who, output logic [31:0] c_seen,
                         output int gnt_cyc);
        bit          exp_owner;
        bit          got;
        logic [31:0] exp_c;
        exp_owner = (req0 && req1) ? ~last_served : req1;
        exp_c     = exp_owner ? ref_alu(A1, B1, ALUOp1) : ref_alu(A0, B0, ALUOp0);
        who = 1'b0; c_seen = '0; gnt_cyc = 0; got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = gnt0 | gnt1;
        end
        if (!got) begin
            checkOutput("gnt_timeout", {31'd0, gnt0 | gnt1}, 32'd1);
            return;
        end
        who     = gnt1;
        gnt_cyc = cyc;
        checkOutput("gnt0", {31'd0, gnt0}, {31'd0, exp_owner == 1'b0});
        checkOutput("gnt1", {31'd0, gnt1}, {31'd0, exp_owner == 1'b1});
        checkOutput("busy_exec", {31'd0, busy}, 32'd1);
        checkOutput("done_in_exec", {31'd0, done0 | done1}, 32'd0);
        last_served = exp_owner;
        if (drop_req) begin
            if (exp_owner) req1 = 1'b0; else req0 = 1'b0;
        end
        if (scramble) begin
            if (exp_owner) begin A1 = $urandom; B1 = $urandom; ALUOp1 = 3'($urandom); end
            else           begin A0 = $urandom; B0 = $urandom; ALUOp0 = 3'($urandom); end
        end
        @(negedge clk);
        checkOutput("done0_resp", {31'd0, done0}, {31'd0, exp_owner == 1'b0});
        checkOutput("done1_resp", {31'd0, done1}, {31'd0, exp_owner == 1'b1});
        checkOutput("gnt_in_resp", {31'd0, gnt0 | gnt1}, 32'd0);
        checkOutput("c_result", C, exp_c);
        c_seen = C;
        for (int i = 0; i < ack_wait; i++) begin
            if (poke_other) begin
                if (exp_owner) begin req0 = 1'b1; ack0 = 1'b1; end
                else           begin req1 = 1'b1; ack1 = 1'b1; end
            end
            @(negedge clk);
            checkOutput("done_hold", {31'd0, exp_owner ? done1 : done0}, 32'd1);
            checkOutput("c_hold", C, exp_c);
            checkOutput("no_grant_in_resp", {31'd0, gnt0 | gnt1}, 32'd0);
        end
        ack0 = 1'b0; ack1 = 1'b0;
        if (exp_owner) ack1 = 1'b1; else ack0 = 1'b1;
        @(negedge clk);
        ack0 = 1'b0; ack1 = 1'b0;
        checkOutput("done_after_ack", {31'd0, done0 | done1}, 32'd0);
        checkOutput("busy_after_ack", {31'd0, busy}, 32'd0);
        checkOutput("c_after_ack", C, exp_c);
    endtask

    initial begin
        bit          who;
        bit          prev_who;
        logic [31:0] c;
        int          gc;
        int          prev_gc;

        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; ack0 = 1'b0; ack1 = 1'b0;
        A0 = '0; B0 = '0; A1 = '0; B1 = '0; ALUOp0 = '0; ALUOp1 = '0;
        last_served = 1'b1;

        // Contention straight out of reset: port 0 wins the first tie.
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1, 3'b000);
        applyStimulus(1'b1, 32'h8000_0000, 32'd4, 3'b101);
        @(negedge clk);
        checkOutput("rst_gnt0", {31'd0, gnt0}, 32'd0);
        checkOutput("rst_gnt1", {31'd0, gnt1}, 32'd0);
        checkOutput("rst_done0", {31'd0, done0}, 32'd0);
        checkOutput("rst_done1", {31'd0, done1}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_c", C, 32'd0);
        reset = 1'b0;
        serve(0, 1'b1, 1'b0, 1'b0, who, c, gc);
        checkOutput("contend_first_owner", {31'd0, who}, 32'd0);
        checkOutput("contend_first_c", c, 32'd0);
        serve(0, 1'b1, 1'b0, 1'b0, who, c, gc);
        checkOutput("contend_second_owner", {31'd0, who}, 32'd1);
        checkOutput("contend_second_c", c, 32'hF800_0000);

        // Single op with A0 scrambled in EXEC, foreign ack and req during RESP.
        A1 = $urandom; B1 = $urandom; ALUOp1 = 3'($urandom);
        applyStimulus(1'b0, 32'd5, 32'd3, 3'b001);
        serve(4, 1'b1, 1'b1, 1'b1, who, c, gc);
        checkOutput("single_owner", {31'd0, who}, 32'd0);
        checkOutput("single_c", c, 32'd2);
        serve(0, 1'b1, 1'b0, 1'b0, who, c, gc);
        checkOutput("late_req1_owner", {31'd0, who}, 32'd1);

        // Compare and shift edge cases.
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1, 3'b110);
        serve(0, 1'b1, 1'b0, 1'b0, who, c, gc);
        checkOutput("sgtu_c", c, 32'd1);
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1, 3'b111);
        serve(0, 1'b1, 1'b0, 1'b0, who, c, gc);
        checkOutput("sgt_c", c, 32'd0);
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd40, 3'b100);
        serve(0, 1'b1, 1'b0, 1'b0, who, c, gc);
        checkOutput("srl_big_c", c, 32'd0);
        applyStimulus(1'b0, 32'h8000_0000, 32'd40, 3'b101);
        serve(1, 1'b1, 1'b0, 1'b0, who, c, gc);
        checkOutput("sra_big_c", c, 32'hFFFF_FFFF);

        // Fairness: both held high, immediate ack, strict alternation.
        applyStimulus(1'b0, $urandom, $urandom, 3'($urandom));
        applyStimulus(1'b1, $urandom, $urandom, 3'($urandom));
        prev_who = 1'b0; prev_gc = 0;
        for (int i = 0; i < 6; i++) begin
            serve(0, 1'b0, 1'b1, 1'b0, who, c, gc);
            if (i > 0) begin
                checkOutput("rr_alternate", {31'd0, who}, {31'd0, ~prev_who});
                checkOutput("rr_spacing", gc - prev_gc, 32'd3);
            end
            prev_who = who;
            prev_gc  = gc;
        end
        req0 = 1'b0; req1 = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 40; i++) begin
            if (!req0 && $urandom_range(0, 1) == 1)
                applyStimulus(1'b0, $urandom,
                              ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                              3'($urandom));
            if (!req1 && $urandom_range(0, 1) == 1)
                applyStimulus(1'b1, $urandom,
                              ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                              3'($urandom));
            if (!req0 && !req1)
                applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom));
            serve($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), who, c, gc);
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        while (busy) @(negedge clk);

        // Asynchronous reset while in EXEC.
        applyStimulus(1'b1, 32'd7, 32'd9, 3'b000);
        @(negedge clk);
        checkOutput("rexec_gnt1_before", {31'd0, gnt1}, 32'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("rexec_gnt1", {31'd0, gnt1}, 32'd0);
        checkOutput("rexec_busy", {31'd0, busy}, 32'd0);
        checkOutput("rexec_c", C, 32'd0);
        req1 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        last_served = 1'b1;

        // Asynchronous reset while in RESP.
        applyStimulus(1'b0, 32'h1234, 32'h1, 3'b000);
        @(negedge clk);
        req0 = 1'b0;
        @(negedge clk);
        checkOutput("rresp_done0_before", {31'd0, done0}, 32'd1);
        checkOutput("rresp_c_before", C, 32'h1235);
        #2 reset = 1'b1;
        #1;
        checkOutput("rresp_done0", {31'd0, done0}, 32'd0);
        checkOutput("rresp_busy", {31'd0, busy}, 32'd0);
        checkOutput("rresp_c", C, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        last_served = 1'b1;

        applyStimulus(1'b1, 32'd100, 32'd58, 3'b001);
        serve(0, 1'b1, 1'b0, 1'b0, who, c, gc);
        checkOutput("post_reset_owner", {31'd0, who}, 32'd1);
        checkOutput("post_reset_c", c, 32'd42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
